mem_io_responder: RTL and testbench

- Memory-side responder for the processor datapath's memory port.
- Serves word-addressed RAM reads and writes, plus a small memory-mapped I/O window:
  - LED register
  - synchronised switch input
  - free-running cycle counter
  - output stream FIFO feeding a display or serial sink.
- Single clock domain; registered read data (1-cycle latency, block-RAM style).

---
 rtl/mem_map_pkg.sv | 26 ++
 rtl/mem_io_responder_out_fifo.sv | 65 ++++++
 rtl/mem_io_responder.sv | 101 ++++++++++
 tb/tb_mem_io_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Address map, status bit layout and shared helpers for the memory-side responder.
package mem_map_pkg;
    localparam int REG_W = 16;

    localparam logic [REG_W-1:0] ADDR_LED       = 16'hFF00;
    localparam logic [REG_W-1:0] ADDR_SW        = 16'hFF01;
    localparam logic [REG_W-1:0] ADDR_CYC       = 16'hFF02;
    localparam logic [REG_W-1:0] ADDR_FIFO_STAT = 16'hFF03;
    localparam logic [REG_W-1:0] ADDR_FIFO_PUSH = 16'hFF04;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_COUNT_LSB = 2;
    localparam int STAT_OVF       = 6;

    function automatic logic [REG_W-1:0] fifo_status(input logic empty, input logic full,
                                                     input logic [3:0] count, input logic ovf);
        logic [REG_W-1:0] st;
        st = '0;
        st[STAT_EMPTY]                       = empty;
        st[STAT_FULL]                        = full;
        st[STAT_COUNT_LSB+3:STAT_COUNT_LSB]  = count;
        st[STAT_OVF]                         = ovf;
        return st;
    endfunction
endpackage

// File: rtl/mem_io_responder_out_fifo.sv
// First-word-fall-through output FIFO with sticky overflow flag.
module out_fifo
    import mem_map_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ovf_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow
);
    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             pop, push_ok;

    // Handshake: a word transfers on every rising edge where out_valid && out_ready;
    // out_valid never depends on out_ready, and the head stays stable until accepted.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        pop      = !empty && out_ready;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        push_ok  = push && (!full || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop);
        ovf_d    = ovf_clr ? 1'b0 : (ovf_q | (push && full && !pop));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !rst) store[wr_ptr_q] <= push_data;
    end

    assign out_valid = !empty;
    assign out_data  = out_valid ? store[rd_ptr_q] : '0;
    assign count     = count_q;
    assign overflow  = ovf_q;
endmodule

// File: rtl/mem_io_responder.sv
// Memory port responder: word RAM plus LED/switch/counter/FIFO I/O window.
// Define MEM_RESP_CYCLE_COUNTER_EN to build the free-running cycle counter at 0xFF02.
module mem_io_responder
    import mem_map_pkg::*;
#(
    parameter int RAM_DEPTH  = 4096,
    parameter int FIFO_DEPTH = 4,
    parameter int LED_W      = 10,
    parameter int SW_W       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      mem_addr,
    input  logic             mem_we,
    input  logic [15:0]      mem_wdata,
    output logic [15:0]      mem_rdata,
    output logic [LED_W-1:0] leds,
    input  logic [SW_W-1:0]  switches,
    output logic             out_valid,
    output logic [15:0]      out_data,
    input  logic             out_ready
);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [REG_W-1:0] ram [RAM_DEPTH];
    logic             in_ram, io_we;
    logic [REG_W-1:0] rdata_q, rdata_d, cyc_rd;
    logic [LED_W-1:0] led_q, led_d;
    logic [SW_W-1:0]  sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic             fifo_push, fifo_ovf_clr, fifo_full, fifo_empty, fifo_ovf;
    logic [CW-1:0]    fifo_count;

    assign in_ram = ((mem_addr >> AW) == 16'd0);
    // RAM writes ignore rst; only the I/O side is held off during reset.
    assign io_we  = mem_we && !rst;

    always_ff @(posedge clk) begin
        if (mem_we && in_ram) ram[mem_addr[AW-1:0]] <= mem_wdata;
    end

`ifdef MEM_RESP_CYCLE_COUNTER_EN
    logic [REG_W-1:0] cyc_q, cyc_d;
    // The write cycle itself counts as 0, so the value loaded for the next cycle is 1.
    always_comb cyc_d = (io_we && mem_addr == ADDR_CYC) ? 16'd1 : cyc_q + 16'd1;
    always_ff @(posedge clk) begin
        if (rst) cyc_q <= '0;
        else     cyc_q <= cyc_d;
    end
    assign cyc_rd = cyc_q;
`else
    assign cyc_rd = '0;
`endif

    always_comb begin
        led_d        = (io_we && mem_addr == ADDR_LED) ? mem_wdata[LED_W-1:0] : led_q;
        sw_meta_d    = switches;
        sw_sync_d    = sw_meta_q;
        fifo_push    = io_we && (mem_addr == ADDR_FIFO_PUSH);
        fifo_ovf_clr = io_we && (mem_addr == ADDR_FIFO_STAT);
        case (mem_addr)
            ADDR_LED:       rdata_d = REG_W'(led_q);
            ADDR_SW:        rdata_d = REG_W'(sw_sync_q);
            ADDR_CYC:       rdata_d = cyc_rd;
            ADDR_FIFO_STAT: rdata_d = fifo_status(fifo_empty, fifo_full, 4'(fifo_count), fifo_ovf);
            default:        rdata_d = in_ram ? ram[mem_addr[AW-1:0]] : '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q   <= '0;
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

    out_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(REG_W)) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (mem_wdata),
        .ovf_clr   (fifo_ovf_clr),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .overflow  (fifo_ovf)
    );

    assign mem_rdata = rdata_q;
    assign leds      = led_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed test-plan checks plus randomized traffic against a queue/array model.
module tb_mem_io_responder;
    localparam int RAM_DEPTH  = 4096;
    localparam int FIFO_DEPTH = 4;
    localparam int LED_W      = 10;
    localparam int SW_W       = 10;
    localparam logic [15:0] IDLE_ADDR = 16'h8000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [15:0]      mem_addr = '0;
    logic             mem_we = 1'b0;
    logic [15:0]      mem_wdata = '0;
    logic [15:0]      mem_rdata;
    logic [LED_W-1:0] leds;
    logic [SW_W-1:0]  switches = '0;
    logic             out_valid;
    logic [15:0]      out_data;
    logic             out_ready = 1'b0;

    mem_io_responder #(.RAM_DEPTH(RAM_DEPTH), .FIFO_DEPTH(FIFO_DEPTH), .LED_W(LED_W), .SW_W(SW_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .leds      (leds),
        .switches  (switches),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: RAM as a sparse map, FIFO as a queue, counter as cycles since last clear.
    bit          model_on = 1'b0;
    logic [15:0] ram_m [int];
    logic [15:0] fifo_m [$];
    logic [15:0] led_m = '0;
    bit          ovf_m = 1'b0;
    int          cyc_no = 0;
    int          cyc_base = 0;
    logic [SW_W-1:0] sw_hist [2];
    logic [15:0] exp_rdata = '0;
    bit          exp_rd_known = 1'b1;

    always @(posedge clk) begin : model
        int          a;
        logic [15:0] rv;
        bit          known;
        bit          pop;
        a     = int'(mem_addr);
        rv    = '0;
        known = 1'b1;
        if (a < RAM_DEPTH) begin
            if (ram_m.exists(a)) rv = ram_m[a];
            else known = 1'b0;
        end else if (a == 'hFF00) rv = led_m;
        else if (a == 'hFF01) rv = 16'(sw_hist[1]);
`ifdef MEM_RESP_CYCLE_COUNTER_EN
        else if (a == 'hFF02) rv = 16'(cyc_no - cyc_base);
`endif
        else if (a == 'hFF03) begin
            rv[0]   = (fifo_m.size() == 0);
            rv[1]   = (fifo_m.size() == FIFO_DEPTH);
            rv[5:2] = 4'(fifo_m.size());
            rv[6]   = ovf_m;
        end
        if (mem_we && a < RAM_DEPTH) ram_m[a] = mem_wdata;
        if (rst) begin
            model_on     = 1'b1;
            exp_rdata    = '0;
            exp_rd_known = 1'b1;
            led_m        = '0;
            fifo_m.delete();
            ovf_m        = 1'b0;
            sw_hist[0]   = '0;
            sw_hist[1]   = '0;
            cyc_base     = cyc_no + 1;
        end else if (model_on) begin
            exp_rdata    = rv;
            exp_rd_known = known;
            pop = (fifo_m.size() > 0) && out_ready;
            if (pop) void'(fifo_m.pop_front());
            if (mem_we) begin
                if (a == 'hFF00) led_m = mem_wdata & 16'((1 << LED_W) - 1);
                if (a == 'hFF02) cyc_base = cyc_no;
                if (a == 'hFF03) ovf_m = 1'b0;
                if (a == 'hFF04) begin
                    if (fifo_m.size() < FIFO_DEPTH) fifo_m.push_back(mem_wdata);
                    else ovf_m = 1'b1;
                end
            end
            sw_hist[1] = sw_hist[0];
            sw_hist[0] = switches;
        end
        cyc_no++;
    end

    always @(negedge clk) begin
        if (model_on) begin
            if (exp_rd_known) check("model_rdata", mem_rdata, exp_rdata);
            check("model_leds", leds, led_m);
            check("model_out_valid", out_valid, fifo_m.size() > 0);
            check("model_out_data", out_data, (fifo_m.size() > 0) ? fifo_m[0] : 16'h0);
        end
    end

    task automatic cyc(input logic [15:0] a, input bit we, input logic [15:0] d);
        mem_addr  = a;
        mem_we    = we;
        mem_wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(IDLE_ADDR, 1'b0, 16'h0);
    endtask

    initial begin
        int r;
        // Reset
        rst = 1'b1;
        idle();
        idle();
        check("reset_rdata", mem_rdata, 32'h0);
        check("reset_leds", leds, 32'h0);
        check("reset_out_valid", out_valid, 32'h0);
        check("reset_out_data", out_data, 32'h0);
        rst = 1'b0;

        // RAM
        cyc(16'h0010, 1'b1, 16'h1234);
        cyc(16'h0010, 1'b0, 16'h0);
        check("ram_read_0010", mem_rdata, 32'h1234);
        cyc(16'h2000, 1'b0, 16'h0);
        check("ram_out_of_range", mem_rdata, 32'h0);

        // LED
        cyc(16'hFF00, 1'b1, 16'hFFFF);
        check("led_write", leds, 32'h3FF);
        cyc(16'hFF00, 1'b0, 16'h0);
        check("led_readback", mem_rdata, 32'h03FF);
        rst = 1'b1;
        cyc(16'hFF00, 1'b0, 16'h0);
        check("led_after_rst", leds, 32'h0);
        check("rdata_after_rst", mem_rdata, 32'h0);
        rst = 1'b0;

        // Switch synchroniser
        switches = 10'h155;
        cyc(16'hFF01, 1'b0, 16'h0);
        check("sw_early", mem_rdata, 32'h0);
        cyc(16'hFF01, 1'b0, 16'h0);
        cyc(16'hFF01, 1'b0, 16'h0);
        check("sw_synced", mem_rdata, 32'h0155);

        // FIFO overflow and drain
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc(16'hFF04, 1'b1, 16'(16'hA1 + i));
        cyc(16'hFF03, 1'b0, 16'h0);
        check("fifo_full_status", mem_rdata, 32'h0012);
        check("fifo_head_a1", out_data, 32'hA1);
        cyc(16'hFF04, 1'b1, 16'hA5);
        cyc(16'hFF03, 1'b0, 16'h0);
        check("fifo_ovf_status", mem_rdata, 32'h0052);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", out_valid, 32'h1);
            check("drain_data", out_data, 32'(16'hA1 + i));
            idle();
        end
        check("drain_empty", out_valid, 32'h0);
        cyc(16'hFF03, 1'b1, 16'h0);
        cyc(16'hFF03, 1'b0, 16'h0);
        check("ovf_cleared", mem_rdata, 32'h0001);

        // Full FIFO with simultaneous push and pop
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc(16'hFF04, 1'b1, 16'(16'hB1 + i));
        out_ready = 1'b1;
        cyc(16'hFF04, 1'b1, 16'hB5);
        out_ready = 1'b0;
        cyc(16'hFF03, 1'b0, 16'h0);
        check("push_pop_full_status", mem_rdata, 32'h0012);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("pp_drain_data", out_data, 32'(16'hB2 + i));
            idle();
        end
        check("pp_drain_empty", out_valid, 32'h0);

        // Cycle counter
        cyc(16'hFF02, 1'b1, 16'h0);
        repeat (4) idle();
        cyc(16'hFF02, 1'b0, 16'h0);
`ifdef MEM_RESP_CYCLE_COUNTER_EN
        check("cyc_after_clear", mem_rdata, 32'h0005);
        cyc(16'hFF02, 1'b1, 16'h0);
        repeat (65534) idle();
        cyc(16'hFF02, 1'b0, 16'h0);
        check("cyc_max", mem_rdata, 32'hFFFF);
        cyc(16'hFF02, 1'b0, 16'h0);
        check("cyc_wrap", mem_rdata, 32'h0000);
`else
        check("cyc_absent", mem_rdata, 32'h0000);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            r = $urandom_range(0, 9);
            if (r <= 3)      mem_addr = 16'($urandom_range(0, 31));
            else if (r == 4) mem_addr = 16'($urandom_range(RAM_DEPTH, 16'hFEFF));
            else if (r <= 8) mem_addr = 16'(16'hFF00 + $urandom_range(0, 7));
            else             mem_addr = 16'(16'hFF00 + $urandom_range(0, 255));
            mem_we    = ($urandom_range(0, 2) == 0);
            mem_wdata = 16'($urandom);
            out_ready = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 15) == 0) switches = SW_W'($urandom);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        out_ready = 1'b0;
        repeat (3) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
